// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity selectors.
// Imported by both the TX and RX paths.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StStart  = 3'd1;
  localparam state_t StData   = 3'd2;
  localparam state_t StParity = 3'd3;
  localparam state_t StStop   = 3'd4;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Bit-index width for a frame of w data bits; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// System-side handshake and serial-line bundle for the UART transmitter.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output Busy
  );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of the latched frame data; odd parity inverts the XOR reduction.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  parity_o
);

  assign parity_o = (^data_i) ^ (par_typ_i == ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// One bit per CLK cycle; TX_OUT and Busy come straight from flops.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_frame_if.slave  bus
);

  localparam int unsigned     CntW    = cnt_width(DATA_WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [CntW-1:0]       cnt_nxt;
  logic                  par_bit;

  // Parity only ever sees the latched copy, so late input changes cannot leak in.
  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data_i    (data_q),
    .par_typ_i (par_typ_q),
    .parity_o  (par_bit)
  );

  assign cnt_nxt = cnt_q + CntW'(1);

  // Next-state logic also decides the next line level, keeping TX_OUT registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    unique case (state_q)
      StIdle: begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b0;
        if (bus.Data_Valid) begin
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          state_d   = StStart;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
        end
      end
      StStart: begin
        state_d = StData;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      StData: begin
        if (cnt_q == LastIdx) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = StParity;
            tx_d    = par_bit;
          end else begin
            state_d = StStop;
            tx_d    = STOP_BIT;
          end
        end else begin
          cnt_d = cnt_nxt;
          tx_d  = data_q[cnt_nxt];
        end
      end
      StParity: begin
        state_d = StStop;
        tx_d    = STOP_BIT;
      end
      StStop: begin
        state_d = StIdle;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-written frame strings checked bit by bit.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, half a cycle after they change.
  task automatic step(input string tag, input logic tx_e, input logic busy_e);
    @(negedge clk);
    check_eq({tag, "/tx"}, 32'(bus.TX_OUT), 32'(tx_e));
    check_eq({tag, "/busy"}, 32'(bus.Busy), 32'(busy_e));
  endtask

  task automatic set_in(input logic [7:0] d, input logic pe, input logic pt, input logic v);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = v;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step($sformatf("%s_idle%0d", tag, i), 1'b1, 1'b0);
  endtask

  // frame: expected line levels from the start bit through the stop bit.
  // scramble flips every input right after acceptance.
  task automatic send(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                      input string frame, input bit scramble);
    set_in(d, pe, pt, 1'b1);
    for (int i = 0; i < frame.len(); i++) begin
      step($sformatf("%s[%0d]", tag, i), frame[i] == "1", 1'b1);
      if (i == 0) begin
        bus.Data_Valid = 1'b0;
        if (scramble) set_in(~d, ~pe, ~pt, 1'b0);
      end
    end
    step({tag, "_end"}, 1'b1, 1'b0);
  endtask

  initial begin
    string frame;
    string bz;
    rst_n = 1'b1;
    set_in(8'h00, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;

    for (int i = 0; i < 3; i++) step($sformatf("rst%0d", i), 1'b1, 1'b0);
    rst_n = 1'b1;
    idle("post_rst", 20);

    send("a5_nopar", 8'hA5, 1'b0, 1'b0, "0101001011", 1'b0);
    send("a5_even", 8'hA5, 1'b1, 1'b0, "01010010101", 1'b0);
    send("a5_odd", 8'hA5, 1'b1, 1'b1, "01010010111", 1'b0);
    send("01_even", 8'h01, 1'b1, 1'b0, "01000000011", 1'b0);
    send("a5_scram", 8'hA5, 1'b1, 1'b0, "01010010101", 1'b1);

    // Request for 0x3C lands during data bit 3 of a 0xA5 frame and must vanish.
    frame = "0101001011";
    set_in(8'hA5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < frame.len(); i++) begin
      step($sformatf("ign[%0d]", i), frame[i] == "1", 1'b1);
      if (i == 0) bus.Data_Valid = 1'b0;
      if (i == 4) set_in(8'h3C, 1'b1, 1'b0, 1'b1);
      if (i == 5) bus.Data_Valid = 1'b0;
    end
    idle("ign", 14);

    // Valid held high: 0xFF, one idle-high cycle, then 0x00.
    frame = "0111111111100000000011";
    bz    = "1111111111011111111110";
    set_in(8'hFF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < frame.len(); i++) begin
      step($sformatf("b2b[%0d]", i), frame[i] == "1", bz[i] == "1");
      if (i == 1) bus.P_DATA = 8'h00;
      if (i == 12) bus.Data_Valid = 1'b0;
    end
    idle("b2b", 3);

    // Reset during data bit 2 of 0xA5 aborts the frame.
    set_in(8'hA5, 1'b0, 1'b0, 1'b1);
    step("mr_start", 1'b0, 1'b1);
    bus.Data_Valid = 1'b0;
    step("mr_d0", 1'b1, 1'b1);
    step("mr_d1", 1'b0, 1'b1);
    step("mr_d2", 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mr_async/tx", 32'(bus.TX_OUT), 32'd1);
    check_eq("mr_async/busy", 32'(bus.Busy), 32'd0);
    step("mr_hold0", 1'b1, 1'b0);
    step("mr_hold1", 1'b1, 1'b0);
    rst_n = 1'b1;
    idle("mr", 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
